sudoku_mask_loader: RTL and testbench

//   Upstream stage of sudoku_ans. Accepts a puzzle as 81 serial digit beats (row-major) on a valid/ready

---
 rtl/sudoku_mask_loader.sv | 161 ++++++++++++++++
 tb/tb_sudoku_mask_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_mask_loader.sv
// -----------------------------------------------------------------------------
// sudoku_mask_loader
//   Takes a sudoku puzzle as 81 serial digit beats in row-major order on a
//   valid/ready handshake. It turns the beats into a 729-bit candidate mask:
//   a given digit v becomes one-hot (bit v-1 of the cell's 9-bit field), and an
//   empty or illegal cell becomes all candidates. The completed mask is then
//   held on a valid/ready output handshake until downstream accepts it.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   clear            synchronous abort; drops any partial or held puzzle
//   dig_valid        dig_data is valid
//   dig_ready        loader accepts a digit this cycle (LOAD state)
//   dig_data         cell digit: 1..9 given, EMPTY_CODE empty, other = error
//   puzzle_mask_bin  candidate mask, bit cell*9+(v-1), cell = row*9+col
//   mask_valid       mask complete and stable (HOLD state)
//   mask_ready       downstream accepts the mask
//   cell_idx         index of the next cell to load, 0..80
//   given_cnt        number of given digits in the current puzzle
//   digit_err        sticky flag: an illegal code was seen in this puzzle
// -----------------------------------------------------------------------------
module sudoku_mask_loader #(
  parameter int          DIG_W      = 4,
  parameter int unsigned EMPTY_CODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             dig_valid,
  output logic             dig_ready,
  input  logic [DIG_W-1:0] dig_data,
  output logic [728:0]     puzzle_mask_bin,
  output logic             mask_valid,
  input  logic             mask_ready,
  output logic [6:0]       cell_idx,
  output logic [6:0]       given_cnt,
  output logic             digit_err
);

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  localparam logic [6:0] LAST_CELL = 7'd80;

  state_e       state_q, state_d;
  logic [6:0]   cell_idx_q, cell_idx_d;
  logic [6:0]   given_cnt_q, given_cnt_d;
  logic         digit_err_q, digit_err_d;
  logic [728:0] mask_q, mask_d;

  logic [10:0]  dec_s;
  logic [9:0]   base_s;

  // Decode one digit code into {illegal, given, 9-bit candidate field}.
  function automatic logic [10:0] decode_digit(input logic [DIG_W-1:0] d);
    logic [10:0] r;
    r = {1'b1, 1'b0, 9'h1FF};
    if ((d >= DIG_W'(1)) && (d <= DIG_W'(9))) begin
      r = {1'b0, 1'b1, 9'(9'h001 << (d - DIG_W'(1)))};
    end else if (d == DIG_W'(EMPTY_CODE)) begin
      r = {1'b0, 1'b0, 9'h1FF};
    end else begin
      r = {1'b1, 1'b0, 9'h1FF};
    end
    return r;
  endfunction

  // Handshake outputs come straight from the state register only.
  assign dig_ready       = (state_q == S_LOAD);
  assign mask_valid      = (state_q == S_HOLD);
  assign puzzle_mask_bin = mask_q;
  assign cell_idx        = cell_idx_q;
  assign given_cnt       = given_cnt_q;
  assign digit_err       = digit_err_q;

  // Next-state and datapath update; clear overrides any coincident handshake.
  always_comb begin
    state_d     = state_q;
    cell_idx_d  = cell_idx_q;
    given_cnt_d = given_cnt_q;
    digit_err_d = digit_err_q;
    mask_d      = mask_q;
    dec_s       = decode_digit(dig_data);
    base_s      = 10'(cell_idx_q) * 10'd9;

    if (clear) begin
      state_d     = S_LOAD;
      cell_idx_d  = 7'd0;
      given_cnt_d = 7'd0;
      digit_err_d = 1'b0;
      mask_d      = {729{1'b1}};
    end else begin
      case (state_q)
        S_LOAD: begin
          if (dig_valid) begin
            mask_d[base_s +: 9] = dec_s[8:0];
            if (dec_s[9]) begin
              given_cnt_d = given_cnt_q + 7'd1;
            end else begin
              given_cnt_d = given_cnt_q;
            end
            if (dec_s[10]) begin
              digit_err_d = 1'b1;
            end else begin
              digit_err_d = digit_err_q;
            end
            // The last cell parks the index at 80 and hands the mask out.
            if (cell_idx_q == LAST_CELL) begin
              state_d    = S_HOLD;
              cell_idx_d = cell_idx_q;
            end else begin
              state_d    = S_LOAD;
              cell_idx_d = cell_idx_q + 7'd1;
            end
          end else begin
            state_d = S_LOAD;
          end
        end
        S_HOLD: begin
          if (mask_ready) begin
            state_d     = S_LOAD;
            cell_idx_d  = 7'd0;
            given_cnt_d = 7'd0;
            digit_err_d = 1'b0;
            mask_d      = {729{1'b1}};
          end else begin
            state_d = S_HOLD;
          end
        end
        default: begin
          state_d     = S_LOAD;
          cell_idx_d  = 7'd0;
          given_cnt_d = 7'd0;
          digit_err_d = 1'b0;
          mask_d      = {729{1'b1}};
        end
      endcase
    end
  end

  // State, counters and mask registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      cell_idx_q  <= 7'd0;
      given_cnt_q <= 7'd0;
      digit_err_q <= 1'b0;
      mask_q      <= {729{1'b1}};
    end else begin
      state_q     <= state_d;
      cell_idx_q  <= cell_idx_d;
      given_cnt_q <= given_cnt_d;
      digit_err_q <= digit_err_d;
      mask_q      <= mask_d;
    end
  end

endmodule

// File: tb/tb_sudoku_mask_loader.sv
// -----------------------------------------------------------------------------
// tb_sudoku_mask_loader
//   Directed bench for sudoku_mask_loader. Each task drives one scenario and
//   compares outputs against hand-derived values. Inputs change 1 ns after the
//   rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_sudoku_mask_loader;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         dig_valid;
  logic         dig_ready;
  logic [3:0]   dig_data;
  logic [728:0] puzzle_mask_bin;
  logic         mask_valid;
  logic         mask_ready;
  logic [6:0]   cell_idx;
  logic [6:0]   given_cnt;
  logic         digit_err;

  int           tests_run;
  int           tests_failed;
  logic [3:0]   puzzle [81];
  logic [728:0] all_ones;
  logic [728:0] exp_mask;

  sudoku_mask_loader #(.DIG_W(4), .EMPTY_CODE(0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear),
    .dig_valid       (dig_valid),
    .dig_ready       (dig_ready),
    .dig_data        (dig_data),
    .puzzle_mask_bin (puzzle_mask_bin),
    .mask_valid      (mask_valid),
    .mask_ready      (mask_ready),
    .cell_idx        (cell_idx),
    .given_cnt       (given_cnt),
    .digit_err       (digit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [3:0] d);
    dig_valid = 1'b1;
    dig_data  = d;
    tick();
    dig_valid = 1'b0;
  endtask

  // Sends beats first..last of the puzzle array back-to-back.
  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      send_beat(puzzle[i]);
    end
  endtask

  task automatic handshake();
    dig_valid  = 1'b0;
    mask_ready = 1'b1;
    tick();
    mask_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear = 1'b0; dig_valid = 1'b0; dig_data = 4'd0; mask_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    tests_run++; if (dig_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_dig_ready got %b want 1", dig_ready); end
    tests_run++; if (mask_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_mask_valid got %b want 0", mask_valid); end
    tests_run++; if (cell_idx !== 7'd0) begin tests_failed++; $display("FAIL reset_cell_idx got %0d want 0", cell_idx); end
    tests_run++; if (given_cnt !== 7'd0) begin tests_failed++; $display("FAIL reset_given_cnt got %0d want 0", given_cnt); end
    tests_run++; if (digit_err !== 1'b0) begin tests_failed++; $display("FAIL reset_digit_err got %b want 0", digit_err); end
    tests_run++; if (puzzle_mask_bin !== all_ones) begin tests_failed++; $display("FAIL reset_mask got %h want all ones", puzzle_mask_bin); end
  endtask

  task automatic test_all_empty();
    for (int i = 0; i < 81; i++) puzzle[i] = 4'd0;
    send_range(0, 79);
    tests_run++; if (mask_valid !== 1'b0) begin tests_failed++; $display("FAIL empty_valid_early got %b want 0", mask_valid); end
    tests_run++; if (cell_idx !== 7'd80) begin tests_failed++; $display("FAIL empty_idx80 got %0d want 80", cell_idx); end
    send_range(80, 80);
    tests_run++; if (mask_valid !== 1'b1) begin tests_failed++; $display("FAIL empty_valid got %b want 1", mask_valid); end
    tests_run++; if (dig_ready !== 1'b0) begin tests_failed++; $display("FAIL empty_dig_ready got %b want 0", dig_ready); end
    tests_run++; if (cell_idx !== 7'd80) begin tests_failed++; $display("FAIL empty_idx_hold got %0d want 80", cell_idx); end
    tests_run++; if (puzzle_mask_bin !== all_ones) begin tests_failed++; $display("FAIL empty_mask got %h want all ones", puzzle_mask_bin); end
    tests_run++; if (given_cnt !== 7'd0) begin tests_failed++; $display("FAIL empty_given got %0d want 0", given_cnt); end
    tests_run++; if (digit_err !== 1'b0) begin tests_failed++; $display("FAIL empty_err got %b want 0", digit_err); end
    handshake();
    tests_run++; if (dig_ready !== 1'b1) begin tests_failed++; $display("FAIL empty_release got %b want 1", dig_ready); end
  endtask

  task automatic test_givens();
    for (int i = 0; i < 81; i++) puzzle[i] = 4'd0;
    puzzle[0]  = 4'd5;
    puzzle[80] = 4'd9;
    exp_mask = all_ones;
    exp_mask[8:0]     = 9'h010;
    exp_mask[728:720] = 9'h100;
    send_range(0, 0);
    tests_run++; if (puzzle_mask_bin[8:0] !== 9'h010) begin tests_failed++; $display("FAIL givens_cell0_early got %h want 010", puzzle_mask_bin[8:0]); end
    tests_run++; if (cell_idx !== 7'd1) begin tests_failed++; $display("FAIL givens_idx1 got %0d want 1", cell_idx); end
    send_range(1, 80);
    tests_run++; if (puzzle_mask_bin !== exp_mask) begin tests_failed++; $display("FAIL givens_mask got %h want %h", puzzle_mask_bin, exp_mask); end
    tests_run++; if (given_cnt !== 7'd2) begin tests_failed++; $display("FAIL givens_cnt got %0d want 2", given_cnt); end
    handshake();
  endtask

  task automatic test_digit_err();
    for (int i = 0; i < 81; i++) puzzle[i] = 4'((i % 9) + 1);
    puzzle[3] = 4'd12;
    send_range(0, 39);
    // Gap: nothing moves while dig_valid is low.
    tick(); tick(); tick();
    tests_run++; if (cell_idx !== 7'd40) begin tests_failed++; $display("FAIL err_gap_idx got %0d want 40", cell_idx); end
    tests_run++; if (given_cnt !== 7'd39) begin tests_failed++; $display("FAIL err_gap_given got %0d want 39", given_cnt); end
    send_range(40, 80);
    tests_run++; if (puzzle_mask_bin[35:27] !== 9'h1FF) begin tests_failed++; $display("FAIL err_cell3 got %h want 1ff", puzzle_mask_bin[35:27]); end
    tests_run++; if (puzzle_mask_bin[44:36] !== 9'h010) begin tests_failed++; $display("FAIL err_cell4 got %h want 010", puzzle_mask_bin[44:36]); end
    tests_run++; if (given_cnt !== 7'd80) begin tests_failed++; $display("FAIL err_given got %0d want 80", given_cnt); end
    tick(); tick(); tick();
    tests_run++; if (digit_err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky got %b want 1", digit_err); end
    handshake();
    tests_run++; if (digit_err !== 1'b0) begin tests_failed++; $display("FAIL err_cleared got %b want 0", digit_err); end
    tests_run++; if (given_cnt !== 7'd0) begin tests_failed++; $display("FAIL err_given_cleared got %0d want 0", given_cnt); end
  endtask

  task automatic test_backpressure();
    int bad;
    for (int i = 0; i < 81; i++) puzzle[i] = 4'd0;
    puzzle[0] = 4'd1;
    exp_mask = all_ones;
    exp_mask[8:0] = 9'h001;
    send_range(0, 80);
    bad = 0;
    mask_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dig_valid = 1'b1;
      dig_data  = 4'(i % 10);
      tick();
      tests_run++;
      if ((puzzle_mask_bin !== exp_mask) || (dig_ready !== 1'b0)) begin
        tests_failed++;
        $display("FAIL bp_hold cyc %0d got dig_ready %b mask %h want 0 / %h", i, dig_ready, puzzle_mask_bin, exp_mask);
      end
    end
    handshake();
    tests_run++; if (cell_idx !== 7'd0) begin tests_failed++; $display("FAIL bp_idx got %0d want 0", cell_idx); end
    tests_run++; if (mask_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_valid got %b want 0", mask_valid); end
    tests_run++; if (puzzle_mask_bin !== all_ones) begin tests_failed++; $display("FAIL bp_mask got %h want all ones", puzzle_mask_bin); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 81; i++) puzzle[i] = 4'd7;
    send_range(0, 39);
    tests_run++; if (cell_idx !== 7'd40) begin tests_failed++; $display("FAIL clr_idx40 got %0d want 40", cell_idx); end
    clear = 1'b1; tick(); clear = 1'b0;
    tests_run++; if (cell_idx !== 7'd0) begin tests_failed++; $display("FAIL clr_idx got %0d want 0", cell_idx); end
    tests_run++; if (given_cnt !== 7'd0) begin tests_failed++; $display("FAIL clr_given got %0d want 0", given_cnt); end
    tests_run++; if (puzzle_mask_bin !== all_ones) begin tests_failed++; $display("FAIL clr_mask got %h want all ones", puzzle_mask_bin); end
    for (int i = 0; i < 81; i++) puzzle[i] = 4'd3;
    send_range(0, 4);
    clear = 1'b1; dig_valid = 1'b1; dig_data = 4'd8;
    tick();
    clear = 1'b0; dig_valid = 1'b0;
    tests_run++; if (cell_idx !== 7'd0) begin tests_failed++; $display("FAIL clr_coinc_idx got %0d want 0", cell_idx); end
    tests_run++; if (given_cnt !== 7'd0) begin tests_failed++; $display("FAIL clr_coinc_given got %0d want 0", given_cnt); end
    tests_run++; if (puzzle_mask_bin !== all_ones) begin tests_failed++; $display("FAIL clr_coinc_mask got %h want all ones", puzzle_mask_bin); end
    // clear while holding a finished mask
    send_range(0, 80);
    clear = 1'b1; tick(); clear = 1'b0;
    tests_run++; if (mask_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_hold_valid got %b want 0", mask_valid); end
    tests_run++; if (puzzle_mask_bin !== all_ones) begin tests_failed++; $display("FAIL clr_hold_mask got %h want all ones", puzzle_mask_bin); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 81; i++) puzzle[i] = 4'd0;
    send_range(0, 80);
    // Digit offered during the handshake cycle must not be taken yet.
    mask_ready = 1'b1; dig_valid = 1'b1; dig_data = 4'd2;
    tick();
    mask_ready = 1'b0;
    tests_run++; if (cell_idx !== 7'd0) begin tests_failed++; $display("FAIL b2b_idx0 got %0d want 0", cell_idx); end
    tick();
    dig_valid = 1'b0;
    tests_run++; if (cell_idx !== 7'd1) begin tests_failed++; $display("FAIL b2b_idx1 got %0d want 1", cell_idx); end
    tests_run++; if (puzzle_mask_bin[8:0] !== 9'h002) begin tests_failed++; $display("FAIL b2b_cell0 got %h want 002", puzzle_mask_bin[8:0]); end
    tests_run++; if (given_cnt !== 7'd1) begin tests_failed++; $display("FAIL b2b_given got %0d want 1", given_cnt); end
    // Async reset mid-load discards the partial puzzle.
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (puzzle_mask_bin !== all_ones) begin tests_failed++; $display("FAIL b2b_rst_mask got %h want all ones", puzzle_mask_bin); end
    tests_run++; if (cell_idx !== 7'd0) begin tests_failed++; $display("FAIL b2b_rst_idx got %0d want 0", cell_idx); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    all_ones     = {729{1'b1}};
    exp_mask     = {729{1'b1}};
    test_reset();
    test_all_empty();
    test_givens();
    test_digit_err();
    test_backpressure();
    test_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
